// File: rtl/alu_operand_stage_if.sv
// ID/EX operand-stage bundle: ID fields, forward sources and EX outputs.
interface alu_operand_stage_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  ALUctrl;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [31:0] ex_store_data;
  logic        load_use_stall;

  modport master (
    output stall, flush, id_valid,
    output id_rs_data, id_rt_data, id_imm,
    output id_rs, id_rt, id_rd,
    output id_alu_op, id_funct, id_alu_src,
    output id_reg_write, id_mem_read,
    output exmem_reg_write, exmem_rd,
    output exmem_result,
    output memwb_reg_write, memwb_rd,
    output memwb_result,
    input  data1, data2, ALUctrl,
    input  ex_valid, ex_reg_write,
    input  ex_mem_read, ex_rd,
    input  ex_store_data, load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid,
    input  id_rs_data, id_rt_data, id_imm,
    input  id_rs, id_rt, id_rd,
    input  id_alu_op, id_funct, id_alu_src,
    input  id_reg_write, id_mem_read,
    input  exmem_reg_write, exmem_rd,
    input  exmem_result,
    input  memwb_reg_write, memwb_rd,
    input  memwb_result,
    output data1, data2, ALUctrl,
    output ex_valid, ex_reg_write,
    output ex_mem_read, ex_rd,
    output ex_store_data, load_use_stall
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX register with ALU control decode, operand forwarding
// and load-use bubble insertion.
module alu_operand_stage (
  input logic              clk,
  input logic              rst,
  alu_operand_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        alu_src;
    logic        shift;
    logic [2:0]  ctrl;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;

  logic [2:0]  ctrl_dec;
  logic        shift_dec;
  logic        lu_stall;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  always_comb begin
    ctrl_dec  = 3'b000;
    shift_dec = 1'b0;
    unique case (bus.id_alu_op)
      2'b00: ctrl_dec = 3'b000;
      2'b01: ctrl_dec = 3'b001;
      2'b11: ctrl_dec = 3'b011;
      default: begin
        unique case (1'b1)
          bus.id_funct == 6'b100000: ctrl_dec = 3'b000;
          bus.id_funct == 6'b100010: ctrl_dec = 3'b001;
          bus.id_funct == 6'b100100: ctrl_dec = 3'b010;
          bus.id_funct == 6'b100101: ctrl_dec = 3'b011;
          bus.id_funct == 6'b000000: begin
            ctrl_dec  = 3'b100;
            shift_dec = 1'b1;
          end
          bus.id_funct == 6'b000010: begin
            ctrl_dec  = 3'b101;
            shift_dec = 1'b1;
          end
          default: ctrl_dec = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    ex_d.valid     = bus.id_valid;
    ex_d.reg_write = bus.id_reg_write & bus.id_valid;
    ex_d.mem_read  = bus.id_mem_read & bus.id_valid;
    ex_d.rd        = bus.id_rd;
    ex_d.rs        = bus.id_rs;
    ex_d.rt        = bus.id_rt;
    ex_d.rs_data   = bus.id_rs_data;
    ex_d.rt_data   = bus.id_rt_data;
    ex_d.imm       = bus.id_imm;
    ex_d.alu_src   = bus.id_alu_src;
    ex_d.shift     = shift_dec;
    ex_d.ctrl      = ctrl_dec;
  end

  // The load sits in EX; its value only exists after MEM.
  assign lu_stall = ex_q.valid & ex_q.mem_read
                  & (ex_q.rd != 5'd0) & bus.id_valid
                  & ((ex_q.rd == bus.id_rs)
                   | (ex_q.rd == bus.id_rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (bus.flush) begin
      ex_q.valid     <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
    end else if (bus.stall) begin
      ex_q <= ex_q;
    end else if (lu_stall) begin
      ex_q.valid     <= 1'b0;
      ex_q.reg_write <= 1'b0;
      ex_q.mem_read  <= 1'b0;
    end else begin
      ex_q <= ex_d;
    end
  end

  logic em_rs, mw_rs, em_rt, mw_rt;

  assign em_rs = bus.exmem_reg_write
               & (bus.exmem_rd != 5'd0)
               & (bus.exmem_rd == ex_q.rs);
  assign mw_rs = bus.memwb_reg_write
               & (bus.memwb_rd != 5'd0)
               & (bus.memwb_rd == ex_q.rs);
  assign em_rt = bus.exmem_reg_write
               & (bus.exmem_rd != 5'd0)
               & (bus.exmem_rd == ex_q.rt);
  assign mw_rt = bus.memwb_reg_write
               & (bus.memwb_rd != 5'd0)
               & (bus.memwb_rd == ex_q.rt);

  always_comb begin
    rs_fwd = ex_q.rs_data;
    if (em_rs)      rs_fwd = bus.exmem_result;
    else if (mw_rs) rs_fwd = bus.memwb_result;
  end

  always_comb begin
    rt_fwd = ex_q.rt_data;
    if (em_rt)      rt_fwd = bus.exmem_result;
    else if (mw_rt) rt_fwd = bus.memwb_result;
  end

  always_comb begin
    bus.data1 = rs_fwd;
    bus.data2 = ex_q.alu_src ? ex_q.imm : rt_fwd;
    if (ex_q.shift) begin
      bus.data1 = rt_fwd;
      bus.data2 = {27'b0, ex_q.imm[10:6]};
    end
  end

  assign bus.ALUctrl        = ex_q.ctrl;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_reg_write   = ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.mem_read;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_store_data  = rt_fwd;
  assign bus.load_use_stall = lu_stall;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed vectors,
// expectations queued per cycle and checked by a monitor.
module tb_alu_operand_stage;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {
    F_D1, F_D2, F_CTRL, F_VALID, F_RD,
    F_LU, F_SD, F_RW, F_MR
  } fld_t;

  typedef struct {
    int          at;
    fld_t        fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] act(fld_t f);
    case (f)
      F_D1:    return bus.data1;
      F_D2:    return bus.data2;
      F_CTRL:  return {29'b0, bus.ALUctrl};
      F_VALID: return {31'b0, bus.ex_valid};
      F_RD:    return {27'b0, bus.ex_rd};
      F_LU:    return {31'b0, bus.load_use_stall};
      F_SD:    return bus.ex_store_data;
      F_RW:    return {31'b0, bus.ex_reg_write};
      default: return {31'b0, bus.ex_mem_read};
    endcase
  endfunction

  task automatic expect_at(int off, fld_t f,
                           logic [31:0] v, string nm);
    exp_t e;
    e.at   = cyc + off;
    e.fld  = f;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        logic [31:0] a;
        a = act(sb[i].fld);
        n_cmp++;
        if (sb[i].at < cyc || a !== sb[i].val) begin
          n_bad++;
          $display("FAIL %s: got %h want %h (cyc %0d/%0d)",
                   sb[i].name, a, sb[i].val, cyc, sb[i].at);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall           = 1'b0;
    bus.flush           = 1'b0;
    bus.id_valid        = 1'b0;
    bus.id_rs_data      = '0;
    bus.id_rt_data      = '0;
    bus.id_imm          = '0;
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.id_rd           = '0;
    bus.id_alu_op       = '0;
    bus.id_funct        = '0;
    bus.id_alu_src      = 1'b0;
    bus.id_reg_write    = 1'b0;
    bus.id_mem_read     = 1'b0;
    bus.exmem_reg_write = 1'b0;
    bus.exmem_rd        = '0;
    bus.exmem_result    = '0;
    bus.memwb_reg_write = 1'b0;
    bus.memwb_rd        = '0;
    bus.memwb_result    = '0;
  endtask

  task automatic id_instr(logic [1:0] op, logic [5:0] fn,
                          logic [4:0] rs, logic [4:0] rt,
                          logic [4:0] rd, logic [31:0] a,
                          logic [31:0] b, logic [31:0] imm,
                          logic src, logic mr);
    bus.id_valid     = 1'b1;
    bus.id_alu_op    = op;
    bus.id_funct     = fn;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_rd        = rd;
    bus.id_rs_data   = a;
    bus.id_rt_data   = b;
    bus.id_imm       = imm;
    bus.id_alu_src   = src;
    bus.id_reg_write = 1'b1;
    bus.id_mem_read  = mr;
  endtask

  initial begin
    int wait_n;
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst = 1'b1;
    bus.id_valid     = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_rd        = 5'($urandom_range(1, 31));
    bus.id_rs_data   = $urandom;
    bus.id_funct     = 6'($urandom);
    bus.id_alu_op    = 2'b10;
    step();
    step();
    rst = 1'b0;
    idle();
    expect_at(0, F_VALID, 0, "rst_valid");
    expect_at(0, F_CTRL,  0, "rst_ctrl");
    expect_at(0, F_RD,    0, "rst_rd");
    expect_at(0, F_D1,    0, "rst_d1");
    expect_at(0, F_D2,    0, "rst_d2");
    expect_at(0, F_RW,    0, "rst_rw");
    step();

    // R-type AND
    id_instr(2'b10, 6'b100100, 5'd5, 5'd6, 5'd8,
             32'hF0F0, 32'h0FF0, 32'h0, 1'b0, 1'b0);
    expect_at(1, F_CTRL,  3'b010,   "and_ctrl");
    expect_at(1, F_D1,    32'hF0F0, "and_d1");
    expect_at(1, F_D2,    32'h0FF0, "and_d2");
    expect_at(1, F_VALID, 1,        "and_valid");
    expect_at(1, F_RD,    8,        "and_rd");
    step();
    // srl shamt 4
    id_instr(2'b10, 6'b000010, 5'd9, 5'd10, 5'd11,
             32'h1234, 32'h8000_0000, 32'h100, 1'b0, 1'b0);
    expect_at(1, F_CTRL, 3'b101,       "srl_ctrl");
    expect_at(1, F_D2,   4,            "srl_d2");
    expect_at(1, F_D1,   32'h8000_0000,"srl_d1");
    step();
    // sub and unknown funct
    id_instr(2'b01, 6'b100100, 5'd1, 5'd2, 5'd3,
             32'h9, 32'h4, 32'h0, 1'b0, 1'b0);
    expect_at(1, F_CTRL, 3'b001, "sub_ctrl");
    step();
    id_instr(2'b10, 6'b101010, 5'd1, 5'd2, 5'd3,
             32'h9, 32'h4, 32'h0, 1'b0, 1'b0);
    expect_at(1, F_CTRL, 3'b000, "other_ctrl");
    step();

    // forwarding priority on rs=3, rt=4
    id_instr(2'b00, 6'b0, 5'd3, 5'd4, 5'd9,
             32'h55, 32'h66, 32'h0, 1'b0, 1'b0);
    step();
    bus.exmem_reg_write = 1'b1;
    bus.exmem_rd        = 5'd3;
    bus.exmem_result    = 32'h11;
    bus.memwb_reg_write = 1'b1;
    bus.memwb_rd        = 5'd3;
    bus.memwb_result    = 32'h22;
    expect_at(0, F_D1, 32'h11, "fwd_exmem");
    expect_at(0, F_D2, 32'h66, "fwd_rt_none");
    step();
    bus.exmem_reg_write = 1'b0;
    expect_at(0, F_D1, 32'h22, "fwd_memwb");
    step();
    bus.exmem_reg_write = 1'b1;
    bus.exmem_rd        = 5'd0;
    bus.memwb_rd        = 5'd0;
    expect_at(0, F_D1, 32'h55, "fwd_rd0");
    step();
    bus.exmem_rd     = 5'd4;
    bus.exmem_result = 32'h77;
    expect_at(0, F_SD, 32'h77, "fwd_store");
    expect_at(0, F_D2, 32'h77, "fwd_rt");
    expect_at(0, F_D1, 32'h55, "fwd_rs_keep");
    step();
    idle();

    // load-use
    id_instr(2'b00, 6'b0, 5'd1, 5'd2, 5'd7,
             32'h100, 32'h0, 32'h4, 1'b1, 1'b1);
    step();
    id_instr(2'b00, 6'b100000, 5'd7, 5'd2, 5'd11,
             32'h0, 32'h3, 32'h0, 1'b0, 1'b0);
    expect_at(0, F_LU,    1,  "lu_set");
    expect_at(1, F_VALID, 0,  "lu_bubble");
    expect_at(1, F_RW,    0,  "lu_bubble_rw");
    expect_at(1, F_LU,    0,  "lu_clear");
    expect_at(2, F_VALID, 1,  "lu_resume");
    expect_at(2, F_RD,    11, "lu_resume_rd");
    step();
    step();
    step();

    // stall holds, flush wins over stall
    id_instr(2'b00, 6'b0, 5'd1, 5'd2, 5'd12,
             32'h10, 32'h20, 32'h0, 1'b0, 1'b0);
    step();
    expect_at(0, F_RD, 12, "cap_rd");
    bus.stall = 1'b1;
    id_instr(2'b01, 6'b0, 5'd5, 5'd6, 5'd13,
             32'hAA, 32'hBB, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      expect_at(k, F_RD,    12,    $sformatf("stall_rd%0d", k));
      expect_at(k, F_D1,    32'h10, $sformatf("stall_d1_%0d", k));
      expect_at(k, F_VALID, 1,     $sformatf("stall_v%0d", k));
      expect_at(k, F_CTRL,  0,     $sformatf("stall_c%0d", k));
    end
    step();
    step();
    step();
    bus.flush = 1'b1;
    expect_at(1, F_VALID, 0, "flush_valid");
    expect_at(1, F_RW,    0, "flush_rw");
    step();
    bus.flush = 1'b0;
    id_instr(2'b00, 6'b0, 5'd1, 5'd2, 5'd14,
             32'h1, 32'h2, 32'h0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    expect_at(1, F_VALID, 0, "rst_stall_valid");
    expect_at(1, F_RD,    0, "rst_stall_rd");
    step();
    rst = 1'b0;
    bus.stall = 1'b0;

    // or-immediate
    id_instr(2'b11, 6'b0, 5'd1, 5'd2, 5'd15,
             32'h1200, 32'h0, 32'h00FF, 1'b1, 1'b0);
    expect_at(1, F_CTRL, 3'b011,   "ori_ctrl");
    expect_at(1, F_D2,   32'h00FF, "ori_d2");
    expect_at(1, F_D1,   32'h1200, "ori_d1");
    step();
    idle();

    wait_n = 0;
    while (sb.size() != 0 && wait_n < 20) begin
      step();
      wait_n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU in the pipelined datapath. It captures decoded instruction fields each cycle and generates the 3-bit ALU control code from ALUOp/funct. It drives the ALU's `data1`/`data2` through EX/MEM and MEM/WB forwarding muxes. It also detects load-use hazards and inserts bubbles under stall/flush control.

## Interface
Parameters:
- none; datapath 32 bits, register index 5 bits, fixed.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  external freeze; hold all EX registers.
- `flush`  in  1  replace the next EX contents with a bubble (branch taken).
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_rs_data`, `id_rt_data`  in  32  register file read values.
- `id_imm`  in  32  sign-extended immediate; bits [10:6] = shamt.
- `id_rs`, `id_rt`, `id_rd`  in  5  register indices; `id_rd` is the already-selected destination.
- `id_alu_op`  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or-immediate.
- `id_funct`  in  6  R-type function field.
- `id_alu_src`  in  1  1: `data2` = immediate.
- `id_reg_write`, `id_mem_read`  in  1  control bits carried to EX.
- `exmem_reg_write`  in  1; `exmem_rd`  in  5; `exmem_result`  in  32  EX/MEM forward source.
- `memwb_reg_write`  in  1; `memwb_rd`  in  5; `memwb_result`  in  32  MEM/WB forward source.
- `data1`, `data2`  out  32  ALU operands.
- `ALUctrl`  out  3  ALU operation code.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`  out  1  registered EX control.
- `ex_rd`  out  5  registered destination.
- `ex_store_data`  out  32  forwarded rt value for stores.
- `load_use_stall`  out  1  request to hold PC and IF/ID.

## Operation
- Register update priority per edge: `rst` > `flush` > `stall` > `load_use_stall` > capture.
- Reset: every register is zero. `ex_valid`=0, `ALUctrl`=000, `ex_rd`=0, and all control bits are 0.
- Flush, and load-use when not stalled, load a bubble: `ex_valid`, `ex_reg_write` and `ex_mem_read` become 0. Other fields are don't-care and hold.
- Stall holds every register unchanged.
- Capture: `ex_valid`<=`id_valid`. `ex_reg_write` and `ex_mem_read` are ANDed with `id_valid`. Data, indices, imm and `alu_src` are registered.
- ALUctrl decode, registered at capture:
  - alu_op 00 -> 000; 01 -> 001; 11 -> 011.
  - alu_op 10, by funct: 100000 -> 000; 100010 -> 001; 100100 -> 010; 100101 -> 011; 000000 (sll) -> 100; 000010 (srl) -> 101; any other -> 000.
- A shift flag is registered when funct is sll/srl with alu_op 10.
- Forwarding, combinational on the registered rs/rt:
  - The EX/MEM source matches when `exmem_reg_write` is set, `exmem_rd`!=0, and `exmem_rd` equals the index. The MEM/WB source matches the same way.
  - EX/MEM has priority over MEM/WB; with no match, the registered value is used.
  - Register 0 is never forwarded.
- Operands:
  - Shift: `data1` = forwarded rt, `data2` = {27'b0, imm[10:6]}.
  - Otherwise: `data1` = forwarded rs; `data2` = imm if `alu_src`, else forwarded rt.
- `ex_store_data` = forwarded rt, always.
- `load_use_stall` is combinational: `ex_valid` & `ex_mem_read` & `ex_rd`!=0 & `id_valid` & (`ex_rd`==`id_rs` | `ex_rd`==`id_rt`).

## Timing
- Latency: 1 cycle from ID inputs to the registered EX fields.
- `data1`, `data2` and `ex_store_data` settle in the same cycle as forwarding-input changes, with no added register.
- `load_use_stall` is valid in the same cycle as the ID inputs. It produces exactly one bubble; on the next cycle the load has moved on and the MEM/WB forward supplies the value.
- Flush and stall asserted together: flush wins and a bubble is inserted.
- Reset asserted mid-stall clears state on that edge; outputs are at reset values the following cycle.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs -> `ex_valid`=0, `ALUctrl`=000, `ex_rd`=0, `data1`=`data2`=0 with forwarding inputs at 0.
- Decode: R-type funct 100100, rs=5 (0xF0F0), rt=6 (0x0FF0) -> next cycle `ALUctrl`=010, `data1`=0xF0F0, `data2`=0x0FF0. Also funct 000010 with shamt 4 -> `ALUctrl`=101, `data2`=4.
- Forward priority: EX rs=3; exmem_rd=3 with result 0x11 and memwb_rd=3 with result 0x22, both writing -> `data1`=0x11. Drop `exmem_reg_write` -> `data1`=0x22. Set rd=0 -> no forward.
- Load-use: EX lw rd=7, ID add rs=7 -> `load_use_stall`=1. Next cycle `ex_valid`=0 and `load_use_stall`=0.
- Stall/flush: capture add, hold `stall` 3 cycles -> EX fields unchanged. Assert `stall`+`flush` -> `ex_valid`=0 next cycle.
- Immediate: alu_op 11, alu_src=1, imm=0x00FF, rs=0x1200 -> `ALUctrl`=011, `data2`=0x00FF.
